// File: rtl/drive_pwm_ctrl.sv
// drive_pwm_ctrl -- two-motor drive controller.
//   Shared PWM timebase, line-follow steering decode, collision hold-off,
//   tone-commanded junction turns and a reversible (backwards-track) mode.
//   Every output is registered: one clock from inputs/counter to pins.
//
// Optional feature: define SOFT_START_EN to ramp the applied duty from 0 up to
//   the target in FULL_PCT/8 % steps per PWM period after reset and on every
//   entry into FWD or TURN. Stop/coast codes snap the ramp back to 0.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   dir_ctrl     [3:2] side 00 straight/01 left/10 right/11 stop; [1:0] 00 none/01 veer/11 pivot
//   col_detect   collision present (level, highest priority after rst)
//   junction     junction reached (level, sampled in FWD only)
//   td_en        tone decision valid (level, used in JUNCTION only)
//   td_dir       tone decision: 00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK
//   hb_en_a/b    left/right H-bridge enables (PWM)
//   hb_in1..4    H-bridge direction pins
//   state        00 FWD, 01 COLLISION, 10 JUNCTION, 11 TURN
//   reversed     1 = driving the track backwards
//   period_tick  one-cycle pulse following the PWM counter wrap
module drive_pwm_ctrl #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned PWM_HZ       = 80,
    parameter int unsigned FULL_PCT     = 80,
    parameter int unsigned VEER_PCT     = 20,
    parameter int unsigned TURN_PERIODS = 40,
    parameter int unsigned COL_HOLD     = 8,
    parameter int unsigned CNT_W        = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dir_ctrl,
    input  logic       col_detect,
    input  logic       junction,
    input  logic       td_en,
    input  logic [1:0] td_dir,
    output logic       hb_en_a,
    output logic       hb_en_b,
    output logic       hb_in1,
    output logic       hb_in2,
    output logic       hb_in3,
    output logic       hb_in4,
    output logic [1:0] state,
    output logic       reversed,
    output logic       period_tick
);

    localparam int unsigned PERIOD = CLK_HZ / PWM_HZ;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] FULL_TH  = CNT_W'(PERIOD * FULL_PCT / 100);
    localparam logic [CNT_W-1:0] VEER_TH  = CNT_W'(PERIOD * VEER_PCT / 100);
    localparam int unsigned HOLD_W = (COL_HOLD > 1) ? $clog2(COL_HOLD) : 1;
    localparam int unsigned TURN_W = $clog2(TURN_PERIODS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(COL_HOLD - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_PERIODS);

    typedef enum logic [1:0] {
        ST_FWD  = 2'b00,
        ST_COL  = 2'b01,
        ST_JCT  = 2'b10,
        ST_TURN = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        DUTY_OFF,
        DUTY_VEER,
        DUTY_FULL
    } duty_e;

    logic [CNT_W-1:0]  cnt_q;
    logic              tick;
    state_e            state_q, state_d;
    logic              reversed_q, reversed_d;
    logic              armed_q, armed_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [1:0]        tdir_q, tdir_d;
    logic              en_a_q, en_a_d;
    logic              en_b_q, en_b_d;
    logic [3:0]        pins_q, pins_d;   // {in1, in2, in3, in4}
    logic              tick_q;

    logic [3:0]        code;
    logic [3:0]        pins_raw;
    logic              hold_pins;
    duty_e             sel_a, sel_b;
    logic              full_pwm, veer_pwm;
    logic              full_eff, veer_eff;

    assign tick     = (cnt_q == CNT_LAST);
    assign full_pwm = (cnt_q < FULL_TH);
    assign veer_pwm = (cnt_q < VEER_TH);

    // Next-state logic. Collision overrides everything; a pending
    // junction/turn is discarded simply by leaving those states.
    always_comb begin
        state_d    = state_q;
        reversed_d = reversed_q;
        armed_d    = armed_q | ~junction;
        hold_d     = hold_q;
        turn_d     = turn_q;
        tdir_d     = tdir_q;
        if (col_detect) begin
            state_d = ST_COL;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_FWD: begin
                    if (junction && armed_q) begin
                        state_d = ST_JCT;
                        armed_d = 1'b0;
                    end
                end
                ST_COL: begin
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_FWD;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                ST_JCT: begin
                    if (td_en) begin
                        tdir_d = td_dir;
                        if (td_dir == 2'b11) begin
                            reversed_d = ~reversed_q;
                            state_d    = ST_FWD;
                        end else begin
                            state_d = ST_TURN;
                            turn_d  = '0;
                        end
                    end
                end
                default: begin
                    // First tick closes the partial entry period; the next
                    // TURN_PERIODS ticks are the counted full periods.
                    if (tick) begin
                        if (turn_q == TURN_LAST) begin
                            state_d = ST_FWD;
                            turn_d  = '0;
                        end else begin
                            turn_d = turn_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Drive decode in forward polarity. A turn reuses the steering table by
    // substituting the matching straight/pivot code.
    always_comb begin
        code      = dir_ctrl;
        sel_a     = DUTY_OFF;
        sel_b     = DUTY_OFF;
        pins_raw  = 4'b0000;
        hold_pins = 1'b1;
        if (state_d == ST_TURN) begin
            case (tdir_d)
                2'b01:   code = 4'b0111;
                2'b10:   code = 4'b1011;
                default: code = 4'b0000;
            endcase
        end
        if (state_d == ST_FWD || state_d == ST_TURN) begin
            hold_pins = 1'b0;
            casez (code)
                4'b11??: pins_raw = 4'b0000;
                4'b0000: begin sel_a = DUTY_FULL; sel_b = DUTY_FULL; pins_raw = 4'b0110; end
                4'b0101: begin sel_a = DUTY_VEER; sel_b = DUTY_FULL; pins_raw = 4'b0110; end
                4'b1001: begin sel_a = DUTY_FULL; sel_b = DUTY_VEER; pins_raw = 4'b0110; end
                4'b0111: begin sel_a = DUTY_FULL; sel_b = DUTY_FULL; pins_raw = 4'b1010; end
                4'b1011: begin sel_a = DUTY_FULL; sel_b = DUTY_FULL; pins_raw = 4'b0101; end
                default: hold_pins = 1'b1;
            endcase
        end
    end

`ifdef SOFT_START_EN
    logic [3:0] ramp_q, ramp_d;
    logic       ramp_ok;
    logic       coast;

    assign coast = (state_d == ST_FWD || state_d == ST_TURN) &&
                   (sel_a == DUTY_OFF) && (sel_b == DUTY_OFF);

    // ramp_d counts 0..8 steps of FULL_PCT/8 %; the duty limit is compared
    // without a divider: cnt < floor(X/800)  <=>  800*(cnt+1) <= X.
    always_comb begin
        ramp_d = ramp_q;
        if (tick && ramp_q != 4'd8) begin
            ramp_d = ramp_q + 4'd1;
        end
        if ((state_d != state_q) && (state_d == ST_FWD || state_d == ST_TURN)) begin
            ramp_d = '0;
        end
        if (coast) begin
            ramp_d = '0;
        end
        ramp_ok  = ((64'(cnt_q) + 64'd1) * 64'd800) <=
                   (64'(PERIOD) * 64'(FULL_PCT) * 64'(ramp_d));
        full_eff = full_pwm & ramp_ok;
        veer_eff = veer_pwm & ramp_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    always_comb begin
        full_eff = full_pwm;
        veer_eff = veer_pwm;
    end
`endif

    // Reversal mirrors the track: each pin pair swaps and the A/B duty
    // sources exchange. Held pins keep their registered value untouched.
    always_comb begin
        duty_e src_a;
        duty_e src_b;
        src_a  = reversed_d ? sel_b : sel_a;
        src_b  = reversed_d ? sel_a : sel_b;
        pins_d = pins_q;
        if (!hold_pins) begin
            pins_d = reversed_d ? {pins_raw[2], pins_raw[3], pins_raw[0], pins_raw[1]}
                                : pins_raw;
        end
        en_a_d = (src_a == DUTY_FULL) ? full_eff : (src_a == DUTY_VEER) ? veer_eff : 1'b0;
        en_b_d = (src_b == DUTY_FULL) ? full_eff : (src_b == DUTY_VEER) ? veer_eff : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            state_q    <= ST_FWD;
            reversed_q <= 1'b0;
            armed_q    <= 1'b1;
            hold_q     <= '0;
            turn_q     <= '0;
            tdir_q     <= '0;
            en_a_q     <= 1'b0;
            en_b_q     <= 1'b0;
            pins_q     <= '0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= tick ? '0 : cnt_q + 1'b1;
            state_q    <= state_d;
            reversed_q <= reversed_d;
            armed_q    <= armed_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            tdir_q     <= tdir_d;
            en_a_q     <= en_a_d;
            en_b_q     <= en_b_d;
            pins_q     <= pins_d;
            tick_q     <= tick;
        end
    end

    assign hb_en_a     = en_a_q;
    assign hb_en_b     = en_b_q;
    assign hb_in1      = pins_q[3];
    assign hb_in2      = pins_q[2];
    assign hb_in3      = pins_q[1];
    assign hb_in4      = pins_q[0];
    assign state       = state_q;
    assign reversed    = reversed_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_drive_pwm_ctrl.sv
// tb_drive_pwm_ctrl -- self-checking bench for drive_pwm_ctrl with
// PERIOD=100, FULL=80 %, VEER=20 %, TURN_PERIODS=3, COL_HOLD=2.
// A percent/phase model predicts every output each cycle; directed scenarios
// add hand-computed duty counts, pin patterns and state sequences.
module tb_drive_pwm_ctrl;

    localparam int PER   = 100;
    localparam int FULLP = 80;
    localparam int VEERP = 20;
    localparam int TP    = 3;
    localparam int CH    = 2;

    localparam logic [1:0] S_FWD = 2'b00;
    localparam logic [1:0] S_COL = 2'b01;
    localparam logic [1:0] S_JCT = 2'b10;
    localparam logic [1:0] S_TRN = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dir_ctrl = 4'b0000;
    logic       col_detect = 1'b0;
    logic       junction = 1'b0;
    logic       td_en = 1'b0;
    logic [1:0] td_dir = 2'b00;
    logic       hb_en_a, hb_en_b, hb_in1, hb_in2, hb_in3, hb_in4;
    logic [1:0] state;
    logic       reversed, period_tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    drive_pwm_ctrl #(
        .CLK_HZ(1000), .PWM_HZ(10), .FULL_PCT(80), .VEER_PCT(20),
        .TURN_PERIODS(3), .COL_HOLD(2), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .dir_ctrl(dir_ctrl), .col_detect(col_detect),
        .junction(junction), .td_en(td_en), .td_dir(td_dir),
        .hb_en_a(hb_en_a), .hb_en_b(hb_en_b),
        .hb_in1(hb_in1), .hb_in2(hb_in2), .hb_in3(hb_in3), .hb_in4(hb_in4),
        .state(state), .reversed(reversed), .period_tick(period_tick)
    );

    wire [3:0] pins = {hb_in1, hb_in2, hb_in3, hb_in4};

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         ph;
    logic [1:0] ms;
    bit         mrev, marm, mvalid;
    int         mhold, mticks;
    logic [1:0] mtd;
    bit         e_ena, e_enb, e_tick;
    logic [3:0] e_pins;

    // duty percentages and forward-polarity pins of a steering code
    task automatic drive_table(input logic [3:0] c, output int da, output int db,
                               output logic [3:0] p, output bit hold);
        da = 0; db = 0; p = 4'b0000; hold = 0;
        if (c[3:2] != 2'b11) begin
            case (c)
                4'b0000: begin da = FULLP; db = FULLP; p = 4'b0110; end
                4'b0101: begin da = VEERP; db = FULLP; p = 4'b0110; end
                4'b1001: begin da = FULLP; db = VEERP; p = 4'b0110; end
                4'b0111: begin da = FULLP; db = FULLP; p = 4'b1010; end
                4'b1011: begin da = FULLP; db = FULLP; p = 4'b0101; end
                default: hold = 1;
            endcase
        end
    endtask

    always @(posedge clk) begin
        logic [1:0] nxt;
        logic [3:0] c, p;
        bit nrev, hold, wrap;
        int da, db, t;
        if (rst) begin
            ph = 0; ms = S_FWD; mrev = 0; marm = 1; mhold = 0; mticks = 0; mtd = 0;
            e_ena = 0; e_enb = 0; e_tick = 0; e_pins = 4'b0000; mvalid = 1;
        end else begin
            wrap = (ph == PER - 1);
            nxt  = ms;
            nrev = mrev;
            if (col_detect) begin
                nxt = S_COL; mhold = 0;
            end else begin
                case (ms)
                    S_FWD: if (junction && marm) begin nxt = S_JCT; marm = 0; end
                    S_COL: if (wrap) begin
                        mhold++;
                        if (mhold >= CH) begin nxt = S_FWD; mhold = 0; end
                    end
                    S_JCT: if (td_en) begin
                        if (td_dir == 2'b11) begin nrev = !mrev; nxt = S_FWD; end
                        else begin mtd = td_dir; mticks = 0; nxt = S_TRN; end
                    end
                    default: if (wrap) begin
                        mticks++;
                        if (mticks == TP + 1) nxt = S_FWD;
                    end
                endcase
            end
            if (!junction) marm = 1;
            c = dir_ctrl;
            if (nxt == S_TRN) c = (mtd == 2'd1) ? 4'b0111 : (mtd == 2'd2) ? 4'b1011 : 4'b0000;
            if (nxt == S_FWD || nxt == S_TRN) drive_table(c, da, db, p, hold);
            else begin da = 0; db = 0; p = 4'b0000; hold = 1; end
            if (nrev) begin t = da; da = db; db = t; p = {p[2], p[3], p[0], p[1]}; end
            e_ena  = (ph * 100 < da * PER);
            e_enb  = (ph * 100 < db * PER);
            if (!hold) e_pins = p;
            e_tick = wrap;
            ms     = nxt;
            mrev   = nrev;
            ph     = (ph + 1) % PER;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("hb_en_a", int'(hb_en_a), int'(e_ena));
            chk("hb_en_b", int'(hb_en_b), int'(e_enb));
            chk("pins", int'(pins), int'(e_pins));
            chk("state", int'(state), int'(ms));
            chk("reversed", int'(reversed), int'(mrev));
            chk("period_tick", int'(period_tick), int'(e_tick));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic window(output int ca, output int cb, output int ct);
        ca = 0; cb = 0; ct = 0;
        repeat (PER) begin
            adv(1);
            ca += int'(hb_en_a);
            cb += int'(hb_en_b);
            ct += int'(period_tick);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim, input string nm);
        int n;
        n = 0;
        while (state != s && n < lim) begin
            adv(1);
            n++;
        end
        chk(nm, int'(state), int'(s));
    endtask

    initial begin
        int ca, cb, ct, n;

        adv(3);
        chk("rst_state", int'(state), 0);
        chk("rst_en", int'({hb_en_a, hb_en_b}), 0);
        chk("rst_pins", int'(pins), 0);
        chk("rst_tick", int'(period_tick), 0);
        rst = 1'b0;

        // straight ahead
        adv(5);
        window(ca, cb, ct);
        chk("straight_a_duty", ca, 80);
        chk("straight_b_duty", cb, 80);
        chk("straight_ticks", ct, 1);
        chk("straight_pins", int'(pins), 4'b0110);

        n = 0;
        while (!period_tick && n < 200) begin adv(1); n++; end
        n = 0;
        do begin adv(1); n++; end while (!period_tick && n < 200);
        chk("tick_spacing", n, 100);

        dir_ctrl = 4'b0101;
        adv(2);
        window(ca, cb, ct);
        chk("veerL_a_duty", ca, 20);
        chk("veerL_b_duty", cb, 80);

        dir_ctrl = 4'b1011;
        adv(2);
        window(ca, cb, ct);
        chk("pivotR_a_duty", ca, 80);
        chk("pivotR_b_duty", cb, 80);
        chk("pivotR_pins", int'(pins), 4'b0101);

        // unknown code: enables off, pins hold
        dir_ctrl = 4'b0100;
        adv(3);
        chk("hold_en", int'({hb_en_a, hb_en_b}), 0);
        chk("hold_pins", int'(pins), 4'b0101);

        dir_ctrl = 4'b1100;
        adv(2);
        chk("stop_pins", int'(pins), 0);

        // collision with a glitch during hold-off
        dir_ctrl = 4'b0000;
        adv(50);
        col_detect = 1'b1;
        adv(1);
        chk("col_en", int'({hb_en_a, hb_en_b}), 0);
        chk("col_state", int'(state), int'(S_COL));
        adv(20);
        col_detect = 1'b0;
        adv(100);
        chk("col_one_tick", int'(state), int'(S_COL));
        col_detect = 1'b1;
        adv(1);
        col_detect = 1'b0;
        adv(100);
        chk("col_glitch_restart", int'(state), int'(S_COL));
        wait_state(S_FWD, 300, "col_release");

        // junction -> pivot left
        adv(10);
        junction = 1'b1;
        adv(1);
        chk("jct_state", int'(state), int'(S_JCT));
        chk("jct_en", int'({hb_en_a, hb_en_b}), 0);
        td_en = 1'b1; td_dir = 2'b01;
        adv(1);
        td_en = 1'b0;
        chk("turnL_state", int'(state), int'(S_TRN));
        chk("turnL_pins", int'(pins), 4'b1010);
        n = 1;
        while (state == S_TRN && n < 500) begin adv(1); n++; end
        n_tests++;
        if (n < 302 || n > 401) begin
            n_fail++;
            $display("FAIL turn_length: got %0d expected 301..400 cycles", n - 1);
        end
        chk("turn_done", int'(state), int'(S_FWD));
        n = 0;
        repeat (200) begin adv(1); if (state != S_FWD) n++; end
        chk("jct_no_reentry", n, 0);
        junction = 1'b0;
        adv(2);

        // BACK: reverse the track
        junction = 1'b1;
        adv(1);
        td_en = 1'b1; td_dir = 2'b11;
        adv(1);
        td_en = 1'b0; junction = 1'b0;
        chk("back1_state", int'(state), int'(S_FWD));
        chk("back1_rev", int'(reversed), 1);
        adv(2);
        chk("rev_straight_pins", int'(pins), 4'b1001);
        dir_ctrl = 4'b0101;
        adv(2);
        window(ca, cb, ct);
        chk("rev_veerL_a_duty", ca, 80);
        chk("rev_veerL_b_duty", cb, 20);
        dir_ctrl = 4'b0000;
        adv(2);

        // reset in the middle of a reversed right turn
        junction = 1'b1;
        adv(1);
        td_en = 1'b1; td_dir = 2'b10;
        adv(1);
        td_en = 1'b0; junction = 1'b0;
        chk("rev_turnR_state", int'(state), int'(S_TRN));
        chk("rev_turnR_pins", int'(pins), 4'b1010);
        adv(40);
        rst = 1'b1;
        adv(1);
        chk("midturn_rst_out",
            int'({hb_en_a, hb_en_b, pins, state, reversed, period_tick}), 0);
        rst = 1'b0;
        adv(3);

        // two BACK commands cancel
        for (int k = 0; k < 2; k++) begin
            junction = 1'b1;
            adv(1);
            td_en = 1'b1; td_dir = 2'b11;
            adv(1);
            td_en = 1'b0; junction = 1'b0;
            chk("back_toggle_rev", int'(reversed), (k == 0) ? 1 : 0);
            adv(3);
        end
        chk("back_twice_pins", int'(pins), 4'b0110);

        adv(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
